// File: rtl/clipper_pkg.sv
// Shared constants, time-of-day record and force FSM encoding for the
// clipper timebase generator.
package clipper_pkg;

    localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;
    localparam logic [31:0] NS_MAX     = 32'd999_999_999;

    typedef struct packed {
        logic [31:0] sec;
        logic [31:0] ns;
    } tb_time_t;

    typedef enum logic {
        F_IDLE  = 1'b0,
        F_APPLY = 1'b1
    } force_state_e;

    // A single step must stay below one second so a rollover carries at most 1 s.
    function automatic logic [31:0] clamp_ns(input logic [63:0] v);
        return (v > 64'(NS_MAX)) ? NS_MAX : v[31:0];
    endfunction

endpackage

// File: rtl/clipper_tb_chan.sv
// One timebase channel: {sec, ns} counter with freeze, accelerate and
// direct load from the force path.
module clipper_tb_chan
    import clipper_pkg::*;
#(
    parameter int INC_W     = 30,
    parameter int ACC_SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INC_W-1:0] inc_ns,
    input  logic             freeze,
    input  logic             accelerate,
    input  logic             load,
    input  tb_time_t         load_val,
    output tb_time_t         tb_time,
    output logic             tb_pps
);

    tb_time_t    time_q, time_d;
    logic        pps_q, pps_d;
    logic [63:0] inc_ext, eff_wide;
    logic [31:0] eff, sum;

    // Shift in a wide domain so accelerated steps saturate instead of wrapping.
    assign inc_ext  = 64'(inc_ns);
    assign eff_wide = accelerate ? (inc_ext << ACC_SHIFT) : inc_ext;
    assign eff      = clamp_ns(eff_wide);
    assign sum      = time_q.ns + eff;

    always_comb begin
        time_d = time_q;
        pps_d  = 1'b0;
        if (load) begin
            time_d = load_val;
        end else if (!freeze) begin
            if (sum >= NS_PER_SEC) begin
                time_d.ns  = sum - NS_PER_SEC;
                time_d.sec = time_q.sec + 32'd1;
                pps_d      = 1'b1;
            end else begin
                time_d.ns = sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            time_q <= '0;
            pps_q  <= 1'b0;
        end else begin
            time_q <= time_d;
            pps_q  <= pps_d;
        end
    end

    assign tb_time = time_q;
    assign tb_pps  = pps_q;

endmodule

// File: rtl/clipper_timebase_gen.sv
// Multi-channel timebase generator with a two-state force handshake that
// loads one channel with an externally supplied {sec, ns} value.
module clipper_timebase_gen
    import clipper_pkg::*;
#(
    parameter  int NB_CH     = 4,
    parameter  int ACC_SHIFT = 4,
    parameter  int INC_W     = 30,
    localparam int CH_W      = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INC_W-1:0]      inc_ns,
    input  logic [NB_CH-1:0]      freeze,
    input  logic [NB_CH-1:0]      accelerate,
    input  logic                  force_vld,
    input  logic [CH_W-1:0]       force_ch,
    input  logic [63:0]           force_time,
    output logic                  force_rdy,
    output logic                  force_err,
    output tb_time_t [NB_CH-1:0]  tb_time,
    output logic [NB_CH-1:0]      tb_pps
);

    force_state_e    state_q, state_d;
    logic [CH_W-1:0] fch_q, fch_d;
    tb_time_t        ftime_q, ftime_d;
    logic            ferr_q, ferr_d;
    logic [31:0]     ch_ext;
    logic            req_bad, apply_ok;

    assign ch_ext  = 32'(force_ch);
    assign req_bad = (force_time[31:0] >= NS_PER_SEC) || (ch_ext >= 32'(NB_CH));

    always_comb begin
        state_d = state_q;
        fch_d   = fch_q;
        ftime_d = ftime_q;
        ferr_d  = ferr_q;
        case (state_q)
            F_IDLE: begin
                if (force_vld) begin
                    state_d = F_APPLY;
                    fch_d   = force_ch;
                    ftime_d = force_time;
                    ferr_d  = req_bad;
                end
            end
            F_APPLY: state_d = F_IDLE;
            default: state_d = F_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= F_IDLE;
            fch_q   <= '0;
            ftime_q <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fch_q   <= fch_d;
            ftime_q <= ftime_d;
            ferr_q  <= ferr_d;
        end
    end

    assign force_rdy = (state_q == F_IDLE);
    assign force_err = (state_q == F_APPLY) && ferr_q;
    assign apply_ok  = (state_q == F_APPLY) && !ferr_q;

    for (genvar i = 0; i < NB_CH; i++) begin : g_ch
        clipper_tb_chan #(
            .INC_W     (INC_W),
            .ACC_SHIFT (ACC_SHIFT)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .inc_ns     (inc_ns),
            .freeze     (freeze[i]),
            .accelerate (accelerate[i]),
            .load       (apply_ok && (fch_q == CH_W'(i))),
            .load_val   (ftime_q),
            .tb_time    (tb_time[i]),
            .tb_pps     (tb_pps[i])
        );
    end

endmodule

// File: tb/tb_clipper_timebase_gen.sv
// Self-checking bench: step table, directed corner sequences and random
// traffic compared against an absolute-nanosecond reference model.
module tb_clipper_timebase_gen;
    import clipper_pkg::*;

    localparam longint unsigned NS64  = 64'd1_000_000_000;
    localparam longint unsigned MOD64 = 64'd4294967296 * 64'd1_000_000_000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [29:0]        inc_ns = '0;
    logic [3:0]         freeze = '0, accelerate = '0;
    logic               force_vld = 1'b0, force_vld_b = 1'b0;
    logic [1:0]         force_ch = '0;
    logic [63:0]        force_time = '0;
    logic               force_rdy, force_err, rdy_b, err_b;
    tb_time_t [3:0]     tb_time;
    tb_time_t [2:0]     tb_time_b;
    logic [3:0]         tb_pps;
    logic [2:0]         pps_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    clipper_timebase_gen #(.NB_CH(4), .ACC_SHIFT(4), .INC_W(30)) dut (
        .clk(clk), .rst(rst), .inc_ns(inc_ns), .freeze(freeze), .accelerate(accelerate),
        .force_vld(force_vld), .force_ch(force_ch), .force_time(force_time),
        .force_rdy(force_rdy), .force_err(force_err), .tb_time(tb_time), .tb_pps(tb_pps)
    );

    // Three-channel copy so a 2-bit channel index can name a channel that does not exist.
    clipper_timebase_gen #(.NB_CH(3), .ACC_SHIFT(4), .INC_W(30)) dut3 (
        .clk(clk), .rst(rst), .inc_ns(inc_ns), .freeze(freeze[2:0]), .accelerate(accelerate[2:0]),
        .force_vld(force_vld_b), .force_ch(force_ch), .force_time(force_time),
        .force_rdy(rdy_b), .force_err(err_b), .tb_time(tb_time_b), .tb_pps(pps_b)
    );

    // Reference model: each channel is a count of nanoseconds since zero.
    longint unsigned m_t [4];
    bit              m_pps [4];
    bit              m_apply = 1'b0, m_a_err = 1'b0;
    int              m_a_ch = 0;
    logic [63:0]     m_a_time = '0;

    function automatic longint unsigned step_of(bit acc, logic [29:0] inc);
        longint unsigned e = acc ? (64'(inc) << 4) : 64'(inc);
        return (e > 64'd999_999_999) ? 64'd999_999_999 : e;
    endfunction

    function automatic logic [63:0] exp_time(int c);
        return {32'(m_t[c] / NS64), 32'(m_t[c] % NS64)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step();
        longint unsigned nt;
        if (rst) begin
            for (int c = 0; c < 4; c++) begin m_t[c] = 0; m_pps[c] = 0; end
            m_apply = 0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                m_pps[c] = 0;
                if (m_apply && !m_a_err && m_a_ch == c) begin
                    m_t[c] = 64'(m_a_time[63:32]) * NS64 + 64'(m_a_time[31:0]);
                end else if (!freeze[c]) begin
                    nt = m_t[c] + step_of(accelerate[c], inc_ns);
                    if (nt >= MOD64) nt -= MOD64;
                    m_pps[c] = (nt / NS64) != (m_t[c] / NS64);
                    m_t[c] = nt;
                end
            end
            if (!m_apply && force_vld) begin
                m_apply  = 1;
                m_a_ch   = int'(force_ch);
                m_a_time = force_time;
                m_a_err  = force_time[31:0] >= 32'd1_000_000_000;
            end else begin
                m_apply = 0;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("time[%0d]", c), tb_time[c], exp_time(c));
            chk($sformatf("pps[%0d]", c), 64'(tb_pps[c]), 64'(m_pps[c]));
        end
        chk("force_rdy", 64'(force_rdy), 64'(!m_apply));
        chk("force_err", 64'(force_err), 64'(m_apply && m_a_err));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [29:0] inc;
        bit          acc;
        logic [31:0] exp_ns;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{30'd8,          1'b0, 32'd8};
        tbl[1] = '{30'd10,         1'b1, 32'd160};
        tbl[2] = '{30'h2000_0000,  1'b1, 32'd999_999_999};
        tbl[3] = '{30'h2000_0000,  1'b0, 32'd536_870_912};
        tbl[4] = '{30'd999_999_999,1'b0, 32'd999_999_999};
        tbl[5] = '{30'h3FFF_FFFF,  1'b0, 32'd999_999_999};
        tbl[6] = '{30'd62_500_000, 1'b1, 32'd999_999_999};
        tbl[7] = '{30'd62_499_999, 1'b1, 32'd999_999_984};

        // Reset state
        do_reset();
        chk("reset_time0", tb_time[0], 64'd0);
        chk("reset_rdy", 64'(force_rdy), 64'd1);

        // Single-step table on ch2
        for (int i = 0; i < 8; i++) begin
            do_reset();
            inc_ns = tbl[i].inc;
            accelerate = tbl[i].acc ? 4'b0100 : 4'b0000;
            cycle();
            chk($sformatf("tbl%0d_ns", i), 64'(tb_time[2].ns), 64'(tbl[i].exp_ns));
            chk($sformatf("tbl%0d_sec", i), 64'(tb_time[2].sec), 64'd0);
        end

        // Ten steps of 8 ns
        accelerate = '0;
        do_reset();
        inc_ns = 30'd8;
        repeat (10) cycle();
        chk("ten_steps_ch0", tb_time[0], {32'd0, 32'd80});

        // Force just below a second boundary, then roll over
        force_vld = 1'b1; force_ch = 2'd1; force_time = {32'd5, 32'd999_999_992};
        cycle();
        force_vld = 1'b0;
        cycle();
        chk("force_ch1_load", tb_time[1], {32'd5, 32'd999_999_992});
        cycle();
        chk("force_ch1_roll", tb_time[1], {32'd6, 32'd0});
        chk("force_ch1_pps", 64'(tb_pps[1]), 64'd1);
        cycle();
        chk("force_ch1_pps_off", 64'(tb_pps[1]), 64'd0);

        // Accelerate and clamp
        do_reset();
        accelerate = 4'b0100; inc_ns = 30'd10;
        repeat (3) cycle();
        chk("acc_ch2", tb_time[2], {32'd0, 32'd480});
        chk("noacc_ch0", tb_time[0], {32'd0, 32'd30});
        inc_ns = 30'h2000_0000;
        cycle();
        chk("clamp_ch2", tb_time[2], {32'd1, 32'd479});
        chk("clamp_pps2", 64'(tb_pps[2]), 64'd1);
        accelerate = '0;

        // Rejected force: bad ns
        inc_ns = 30'd8;
        force_vld = 1'b1; force_ch = 2'd0; force_time = {32'd3, 32'd1_000_000_000};
        cycle();
        force_vld = 1'b0;
        chk("bad_ns_err", 64'(force_err), 64'd1);
        cycle();
        chk("bad_ns_err_off", 64'(force_err), 64'd0);

        // Rejected force: channel index past NB_CH on the 3-channel copy
        do_reset();
        force_vld_b = 1'b1; force_ch = 2'd3; force_time = {32'd7, 32'd5};
        cycle();
        force_vld_b = 1'b0;
        chk("bad_ch_err", 64'(err_b), 64'd1);
        cycle();
        chk("bad_ch_err_off", 64'(err_b), 64'd0);
        chk("bad_ch_rdy", 64'(rdy_b), 64'd1);
        for (int k = 0; k < 3; k++)
            chk($sformatf("bad_ch_time[%0d]", k), tb_time_b[k], exp_time(k));

        // Force into a frozen channel
        freeze = 4'b0001;
        force_vld = 1'b1; force_ch = 2'd0; force_time = {32'd1, 32'd100};
        cycle();
        force_vld = 1'b0;
        cycle();
        chk("frz_load", tb_time[0], {32'd1, 32'd100});
        repeat (3) begin
            cycle();
            chk("frz_hold", tb_time[0], {32'd1, 32'd100});
            chk("frz_pps", 64'(tb_pps[0]), 64'd0);
        end
        freeze = '0;

        // Seconds wrap on ch3
        inc_ns = 30'd1;
        force_vld = 1'b1; force_ch = 2'd3; force_time = {32'hFFFF_FFFF, 32'd999_999_999};
        cycle();
        force_vld = 1'b0;
        cycle();
        chk("wrap_load", tb_time[3], {32'hFFFF_FFFF, 32'd999_999_999});
        cycle();
        chk("wrap_time", tb_time[3], {32'd0, 32'd0});
        chk("wrap_pps", 64'(tb_pps[3]), 64'd1);

        // Held force_vld: acceptance every other cycle
        force_vld = 1'b1; force_ch = 2'd2; force_time = {32'd2, 32'd2};
        repeat (6) cycle();
        force_vld = 1'b0;
        cycle();

        // Reset during the apply cycle discards the force
        force_vld = 1'b1; force_ch = 2'd1; force_time = {32'd9, 32'd9};
        cycle();
        force_vld = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_apply_rdy", 64'(force_rdy), 64'd1);
        chk("rst_apply_ch1", tb_time[1], 64'd0);
        cycle();
        chk("rst_apply_after", tb_time[1], {32'd0, 32'd1});

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            inc_ns     = ($urandom_range(0, 3) == 0) ? 30'($urandom) : 30'($urandom_range(0, 2_000_000));
            freeze     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            accelerate = 4'($urandom);
            force_vld  = ($urandom_range(0, 4) == 0);
            force_ch   = 2'($urandom);
            force_time = {32'($urandom),
                          ($urandom_range(0, 5) == 0) ? 32'($urandom_range(32'd1_000_000_000, 32'hFFFF_FFFF))
                                                      : 32'($urandom_range(0, 999_999_999))};
            if (n % 97 == 50) rst = 1'b1;
            cycle();
            rst = 1'b0;
        end
        force_vld = 1'b0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clipper_timebase_gen.md
CLIPPER_TIMEBASE_GEN -- requirements
Module: clipper_timebase_gen

Interface
REQ-001 Parameter NB_CH, default 4: number of independent timebase channels.
REQ-002 Parameter ACC_SHIFT, default 4: accelerate mode multiplies the increment by 2**ACC_SHIFT.
REQ-003 Parameter INC_W, default 30: width of the nanosecond increment.
REQ-004 clk  in  1: single clock for the whole block.
REQ-005 rst  in  1: reset, synchronous and active-high.
REQ-006 inc_ns  in  INC_W: nanoseconds added per clk; shared by all channels.
REQ-007 freeze  in  NB_CH: per channel, hold the time value.
REQ-008 accelerate  in  NB_CH: per channel, use the shifted increment.
REQ-009 force_vld  in  1: force request valid.
REQ-010 force_ch  in  $clog2(NB_CH): target channel of the force.
REQ-011 force_time  in  64: forced value, {sec[31:0], ns[31:0]}.
REQ-012 force_rdy  out  1: force request can be accepted.
REQ-013 force_err  out  1: one-cycle pulse when a force is rejected.
REQ-014 tb_time  out  NB_CH x 64: per-channel time, {sec, ns}, registered.
REQ-015 tb_pps  out  NB_CH: one-cycle pulse on each second rollover.

Function
REQ-016 Each channel SHALL compute eff = accelerate ? inc_ns<<ACC_SHIFT : inc_ns, zero-extended to 32 bits.
- eff SHALL clamp to NS_MAX = 999_999_999.
REQ-017 Each clk, for an unfrozen and unforced channel:
- If ns+eff >= NS_PER_SEC: ns <= ns+eff-NS_PER_SEC, sec <= sec+1, and tb_pps SHALL pulse on that same update cycle.
- Otherwise: ns <= ns+eff, with no pps pulse.
REQ-018 sec SHALL wrap from 0xFFFF_FFFF to 0 without error; the pps pulse still fires on the wrap.
REQ-019 A frozen channel SHALL hold tb_time and SHALL NOT pulse tb_pps.
REQ-020 An update SHALL be visible on tb_time one clk after the sampling edge (latency 1).
REQ-021 The force state machine SHALL have two states, F_IDLE and F_APPLY.
- force_rdy = 1 only in F_IDLE.
- F_IDLE -> F_APPLY on force_vld && force_rdy.
- F_APPLY -> F_IDLE unconditionally after one cycle.
REQ-022 On acceptance, force_ch and force_time SHALL be captured into a register.
- In F_APPLY the target channel SHALL load the captured value instead of incrementing.
- The load SHALL take effect even if the channel is frozen.
- The loaded value appears on tb_time on the cycle after F_APPLY.
- No pps pulse SHALL be generated on the load cycle.
REQ-023 A force SHALL be rejected when force_time[31:0] >= NS_PER_SEC or force_ch >= NB_CH.
- A rejected request is still accepted (handshake completes).
- force_err SHALL pulse for one cycle in F_APPLY and no channel SHALL be loaded.
REQ-024 Channels not targeted by a force SHALL keep normal behaviour during F_APPLY.
REQ-025 force_vld held high SHALL produce at most one acceptance every two cycles.

Reset
REQ-026 On rst: tb_time = 0, tb_pps = 0, force_err = 0, state = F_IDLE, force_rdy = 1 on the cycle after rst deasserts.
REQ-027 A rst asserted during F_APPLY SHALL discard the pending force.

Structure
REQ-028 clipper_pkg SHALL hold NS_PER_SEC = 1_000_000_000, NS_MAX, and typedef tb_time_t (packed struct {sec[31:0], ns[31:0]}).
REQ-029 Per-channel counting SHALL live in a sub-module, clipper_tb_chan, instantiated NB_CH times.
- The force state machine stays in the top level.

Verification
REQ-030 Reset, then inc_ns = 8 for 10 cycles -> ch0 = {0, 80}, tb_pps never asserted.
REQ-031 Force ch1 = {5, 999_999_992}, inc_ns = 8 -> the next update gives {6, 0} and tb_pps[1] pulses exactly once.
REQ-032 accelerate[2] = 1, ACC_SHIFT = 4, inc_ns = 10 -> ch2 advances 160 ns per clk; inc_ns = 2^29 -> step clamped to 999_999_999.
REQ-033 Force ns = 1_000_000_000 -> force_err pulses once and all channels are unchanged; force with force_ch = NB_CH -> force_err pulses.
REQ-034 freeze[0] = 1 plus a force of ch0 = {1, 100} in the same window -> ch0 = {1, 100} and held, no pps pulse.
REQ-035 ch3 at {0xFFFF_FFFF, 999_999_999}, inc_ns = 1 -> {0, 0} with tb_pps[3] pulsing; rst during F_APPLY -> no load, force_rdy = 1 after reset.
